// File: rtl/pgm_ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pgm_ddr_pkg
// Description : Shared types and constants for the programmable DDRAM bridge:
//               FSM state encoding, default address width, fixed burst count,
//               read-timeout fill pattern and a byte-enable merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pgm_ddr_pkg;

  localparam int          AW_DEF          = 29;
  localparam logic [7:0]  BURST_ONE       = 8'd1;
  localparam logic [63:0] RD_TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DONE = 3'd3,
    ST_WR_CMD  = 3'd4
  } ddr_state_t;

  // Overlay the enabled bytes of new_data onto old_data.
  function automatic logic [63:0] merge_be(input logic [63:0] old_data,
                                           input logic [63:0] new_data,
                                           input logic [7:0]  be);
    logic [63:0] res;
    res = old_data;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) res[8*i +: 8] = new_data[8*i +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pgm_ddram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : pgm_ddram_bridge_if / pgm_ddr_avl_if
// Description : Bus bundles for the bridge. pgm_ddram_bridge_if is the core's
//               simple command bus (arbiter/loader = master, bridge = slave);
//               pgm_ddr_avl_if is the Avalon-MM DDRAM port (bridge = master).
// Revision    : 1.0 - initial release
// ============================================================================
interface pgm_ddram_bridge_if
  import pgm_ddr_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic          req_rd;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_din;
  logic [7:0]    req_be;
  logic          req_busy;
  logic [63:0]   rsp_dout;
  logic          rsp_valid;

  modport master (output req_rd, req_we, req_addr, req_din, req_be,
                  input  req_busy, rsp_dout, rsp_valid);
  modport slave  (input  req_rd, req_we, req_addr, req_din, req_be,
                  output req_busy, rsp_dout, rsp_valid);
endinterface

interface pgm_ddr_avl_if
  import pgm_ddr_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic          ddr_rd;
  logic          ddr_we;
  logic [AW-1:0] ddr_addr;
  logic [7:0]    ddr_burstcnt;
  logic [63:0]   ddr_din;
  logic [7:0]    ddr_be;
  logic          ddr_busy;
  logic [63:0]   ddr_dout;
  logic          ddr_dout_ready;

  modport master (output ddr_rd, ddr_we, ddr_addr, ddr_burstcnt, ddr_din, ddr_be,
                  input  ddr_busy, ddr_dout, ddr_dout_ready);
  modport slave  (input  ddr_rd, ddr_we, ddr_addr, ddr_burstcnt, ddr_din, ddr_be,
                  output ddr_busy, ddr_dout, ddr_dout_ready);
endinterface
`default_nettype wire

// File: rtl/pgm_ddr_rdcache.sv
`default_nettype none
// ============================================================================
// Module      : pgm_ddr_rdcache
// Description : Single-line read cache (tag, valid, 64-bit data). Filled on a
//               DDR read return, byte-merged on a write to the tagged address,
//               invalidated by reset or by a read timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pgm_ddr_rdcache
  import pgm_ddr_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] i_lookup_addr,
  output logic          o_hit,
  output logic [63:0]   o_data,
  input  logic          i_fill,
  input  logic [AW-1:0] i_fill_addr,
  input  logic [63:0]   i_fill_data,
  input  logic          i_wr,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [63:0]   i_wr_data,
  input  logic [7:0]    i_wr_be,
  input  logic          i_inv
);

  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [63:0]   r_data;

  // Line update: invalidate beats fill, fill beats write-merge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_inv) begin
      r_valid <= 1'b0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_addr;
      r_data  <= i_fill_data;
    end else if (i_wr && r_valid && (i_wr_addr == r_tag)) begin
      r_data  <= merge_be(r_data, i_wr_data, i_wr_be);
    end
  end

  assign o_hit  = r_valid && (i_lookup_addr == r_tag);
  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/pgm_ddram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : pgm_ddram_bridge
// Description : Turns each command on the core's DDRAM command bus into one
//               single-beat Avalon-MM access. Reads return through a one-cycle
//               rsp_valid pulse; writes are posted. A watchdog aborts reads
//               that never see readdatavalid and returns all-ones.
//               Optional one-line read cache: define PGM_DDR_RDCACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pgm_ddram_bridge
  import pgm_ddr_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int TMO_W = 10
) (
  input  logic              fixed_50m_clk,
  input  logic              reset,
  pgm_ddram_bridge_if.slave req,
  pgm_ddr_avl_if.master     ddr
);

  ddr_state_t       r_state,    w_state_nxt;
  logic             r_ddr_rd,   w_ddr_rd_nxt;
  logic             r_ddr_we,   w_ddr_we_nxt;
  logic [AW-1:0]    r_ddr_addr, w_ddr_addr_nxt;
  logic [63:0]      r_ddr_din,  w_ddr_din_nxt;
  logic [7:0]       r_ddr_be,   w_ddr_be_nxt;
  logic [63:0]      r_rsp_dout, w_rsp_dout_nxt;
  logic             r_rsp_valid, w_rsp_valid_nxt;
  logic [TMO_W-1:0] r_wdog,     w_wdog_nxt;
  logic [TMO_W-1:0] w_wdog_inc;
  logic             w_timeout;
  logic             w_hit;
  logic [63:0]      w_cache_data;

  assign w_wdog_inc = r_wdog + 1'b1;
  // Abort once the count would reach all-ones, i.e. after 2**TMO_W-1 silent cycles.
  assign w_timeout  = (r_state == ST_RD_WAIT) && !ddr.ddr_dout_ready &&
                      (w_wdog_inc == {TMO_W{1'b1}});

`ifdef PGM_DDR_RDCACHE_EN
  logic w_fill;
  logic w_wr;

  assign w_fill = (r_state == ST_RD_WAIT) && ddr.ddr_dout_ready;
  assign w_wr   = (r_state == ST_IDLE) && req.req_we;

  pgm_ddr_rdcache #(.AW(AW)) u_rdcache (
    .clk           (fixed_50m_clk),
    .rst           (reset),
    .i_lookup_addr (req.req_addr),
    .o_hit         (w_hit),
    .o_data        (w_cache_data),
    .i_fill        (w_fill),
    .i_fill_addr   (r_ddr_addr),
    .i_fill_data   (ddr.ddr_dout),
    .i_wr          (w_wr),
    .i_wr_addr     (req.req_addr),
    .i_wr_data     (req.req_din),
    .i_wr_be       (req.req_be),
    .i_inv         (w_timeout)
  );
`else
  assign w_hit        = 1'b0;
  assign w_cache_data = '0;
`endif

  // Next-state and next-output decode; every register holds unless a state acts.
  always_comb begin
    w_state_nxt     = r_state;
    w_ddr_rd_nxt    = r_ddr_rd;
    w_ddr_we_nxt    = r_ddr_we;
    w_ddr_addr_nxt  = r_ddr_addr;
    w_ddr_din_nxt   = r_ddr_din;
    w_ddr_be_nxt    = r_ddr_be;
    w_rsp_dout_nxt  = r_rsp_dout;
    w_rsp_valid_nxt = 1'b0;
    w_wdog_nxt      = r_wdog;
    case (r_state)
      ST_IDLE: begin
        w_wdog_nxt = '0;
        if (req.req_we || req.req_rd) begin
          w_ddr_addr_nxt = req.req_addr;
          w_ddr_din_nxt  = req.req_din;
          w_ddr_be_nxt   = req.req_be;
        end
        if (req.req_we) begin
          w_ddr_we_nxt = 1'b1;
          w_state_nxt  = ST_WR_CMD;
        end else if (req.req_rd) begin
          if (w_hit) begin
            w_rsp_dout_nxt  = w_cache_data;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = ST_RD_DONE;
          end else begin
            w_ddr_rd_nxt = 1'b1;
            w_state_nxt  = ST_RD_CMD;
          end
        end
      end
      ST_RD_CMD: begin
        if (!ddr.ddr_busy) begin
          w_ddr_rd_nxt = 1'b0;
          w_state_nxt  = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        w_wdog_nxt = w_wdog_inc;
        if (ddr.ddr_dout_ready) begin
          w_rsp_dout_nxt  = ddr.ddr_dout;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RD_DONE;
        end else if (w_timeout) begin
          w_rsp_dout_nxt  = RD_TIMEOUT_DATA;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = ST_RD_DONE;
        end
      end
      ST_RD_DONE: begin
        // req_rd is still high from the completed command; do not re-issue it.
        w_state_nxt = ST_IDLE;
      end
      ST_WR_CMD: begin
        if (!ddr.ddr_busy) begin
          w_ddr_we_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_ddr_rd_nxt = 1'b0;
        w_ddr_we_nxt = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge fixed_50m_clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ddr_rd    <= 1'b0;
      r_ddr_we    <= 1'b0;
      r_ddr_addr  <= '0;
      r_ddr_din   <= '0;
      r_ddr_be    <= '0;
      r_rsp_dout  <= '0;
      r_rsp_valid <= 1'b0;
      r_wdog      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ddr_rd    <= w_ddr_rd_nxt;
      r_ddr_we    <= w_ddr_we_nxt;
      r_ddr_addr  <= w_ddr_addr_nxt;
      r_ddr_din   <= w_ddr_din_nxt;
      r_ddr_be    <= w_ddr_be_nxt;
      r_rsp_dout  <= w_rsp_dout_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_wdog      <= w_wdog_nxt;
    end
  end

  // req_busy depends only on the state register, never on ddr_busy.
  assign req.req_busy  = (r_state != ST_IDLE);
  assign req.rsp_dout  = r_rsp_dout;
  assign req.rsp_valid = r_rsp_valid;

  assign ddr.ddr_rd       = r_ddr_rd;
  assign ddr.ddr_we       = r_ddr_we;
  assign ddr.ddr_addr     = r_ddr_addr;
  assign ddr.ddr_burstcnt = BURST_ONE;
  assign ddr.ddr_din      = r_ddr_din;
  assign ddr.ddr_be       = r_ddr_be;

endmodule
`default_nettype wire

// File: tb/tb_pgm_ddram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_pgm_ddram_bridge
// Description : Directed self-checking bench for pgm_ddram_bridge (TMO_W=4).
//               Cache scenario is compiled in when PGM_DDR_RDCACHE_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pgm_ddram_bridge;

  localparam int AW = 29;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n_rd = 0, n_we = 0, n_valid = 0;

  pgm_ddram_bridge_if #(.AW(AW)) req_if ();
  pgm_ddr_avl_if      #(.AW(AW)) ddr_if ();

  pgm_ddram_bridge #(.AW(AW), .TMO_W(4)) dut (
    .fixed_50m_clk (clk),
    .reset         (reset),
    .req           (req_if),
    .ddr           (ddr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counters of observed strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (ddr_if.ddr_rd)    n_rd++;
    if (ddr_if.ddr_we)    n_we++;
    if (req_if.rsp_valid) n_valid++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++; if (req_if.req_busy !== 1'b0)  begin errors++; $display("FAIL reset_req_busy got %b exp 0", req_if.req_busy); end
    checks++; if (req_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", req_if.rsp_valid); end
    checks++; if (req_if.rsp_dout !== 64'h0) begin errors++; $display("FAIL reset_rsp_dout got %h exp 0", req_if.rsp_dout); end
    checks++; if (ddr_if.ddr_rd !== 1'b0 || ddr_if.ddr_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we got %b%b exp 00", ddr_if.ddr_rd, ddr_if.ddr_we); end
    checks++; if (ddr_if.ddr_addr !== 29'h0 || ddr_if.ddr_din !== 64'h0 || ddr_if.ddr_be !== 8'h0) begin errors++; $display("FAIL reset_addr_din_be got %h %h %h exp 0", ddr_if.ddr_addr, ddr_if.ddr_din, ddr_if.ddr_be); end
    checks++; if (ddr_if.ddr_burstcnt !== 8'd1) begin errors++; $display("FAIL burstcnt got %0d exp 1", ddr_if.ddr_burstcnt); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_read_basic();
    int rd0, v0;
    rd0 = n_rd; v0 = n_valid;
    req_if.req_addr = 29'h1234; req_if.req_rd = 1'b1; ddr_if.ddr_busy = 1'b0;
    step();
    checks++; if (ddr_if.ddr_rd !== 1'b1 || ddr_if.ddr_addr !== 29'h1234) begin errors++; $display("FAIL rd_issue got rd=%b addr=%h exp 1 1234", ddr_if.ddr_rd, ddr_if.ddr_addr); end
    checks++; if (req_if.req_busy !== 1'b1) begin errors++; $display("FAIL rd_req_busy got %b exp 1", req_if.req_busy); end
    step();
    checks++; if (ddr_if.ddr_rd !== 1'b0) begin errors++; $display("FAIL rd_drop got %b exp 0", ddr_if.ddr_rd); end
    for (int i = 0; i < 4; i++) step();
    ddr_if.ddr_dout = 64'h0123_4567_89AB_CDEF; ddr_if.ddr_dout_ready = 1'b1;
    step();
    ddr_if.ddr_dout_ready = 1'b0; ddr_if.ddr_dout = 64'h0;
    checks++; if (req_if.rsp_valid !== 1'b1 || req_if.rsp_dout !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL rd_data got v=%b d=%h exp 1 0123456789abcdef", req_if.rsp_valid, req_if.rsp_dout); end
    // req_rd stays high across the RD_DONE edge
    step();
    req_if.req_rd = 1'b0;
    checks++; if (req_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got %b exp 0", req_if.rsp_valid); end
    step(); step(); step();
    checks++; if (n_rd - rd0 != 1) begin errors++; $display("FAIL rd_single_issue got %0d exp 1", n_rd - rd0); end
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL rd_valid_count got %0d exp 1", n_valid - v0); end
  endtask

  task automatic test_read_busy();
    int rd0;
    rd0 = n_rd;
    req_if.req_addr = 29'h0ABCDE; req_if.req_rd = 1'b1; ddr_if.ddr_busy = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (ddr_if.ddr_rd !== 1'b1 || ddr_if.ddr_addr !== 29'h0ABCDE) begin errors++; $display("FAIL rdbusy_hold[%0d] got rd=%b addr=%h exp 1 0abcde", i, ddr_if.ddr_rd, ddr_if.ddr_addr); end
      step();
    end
    ddr_if.ddr_busy = 1'b0;
    step();
    checks++; if (ddr_if.ddr_rd !== 1'b0) begin errors++; $display("FAIL rdbusy_drop got %b exp 0", ddr_if.ddr_rd); end
    checks++; if (n_rd - rd0 != 5) begin errors++; $display("FAIL rdbusy_cycles got %0d exp 5", n_rd - rd0); end
    ddr_if.ddr_dout = 64'hA5A5_0000_5A5A_FFFF; ddr_if.ddr_dout_ready = 1'b1;
    step();
    ddr_if.ddr_dout_ready = 1'b0;
    checks++; if (req_if.rsp_valid !== 1'b1 || req_if.rsp_dout !== 64'hA5A5_0000_5A5A_FFFF) begin errors++; $display("FAIL rdbusy_data got v=%b d=%h exp 1 a5a500005a5affff", req_if.rsp_valid, req_if.rsp_dout); end
    req_if.req_rd = 1'b0;
    step(); step();
  endtask

  task automatic test_write();
    int we0, v0;
    we0 = n_we; v0 = n_valid;
    req_if.req_addr = 29'h100; req_if.req_be = 8'h0C; req_if.req_din = 64'h0000_0000_BEEF_0000;
    req_if.req_we = 1'b1; ddr_if.ddr_busy = 1'b1;
    step();
    req_if.req_we = 1'b0;
    checks++; if (ddr_if.ddr_we !== 1'b1 || ddr_if.ddr_be !== 8'h0C || ddr_if.ddr_addr !== 29'h100 || ddr_if.ddr_din !== 64'h0000_0000_BEEF_0000) begin errors++; $display("FAIL wr_issue got we=%b be=%h addr=%h din=%h", ddr_if.ddr_we, ddr_if.ddr_be, ddr_if.ddr_addr, ddr_if.ddr_din); end
    step();
    checks++; if (req_if.req_busy !== 1'b1) begin errors++; $display("FAIL wr_req_busy got %b exp 1", req_if.req_busy); end
    // Write pulse while busy must be dropped
    req_if.req_addr = 29'h200; req_if.req_we = 1'b1;
    step();
    req_if.req_we = 1'b0; ddr_if.ddr_busy = 1'b0;
    step();
    checks++; if (req_if.req_busy !== 1'b0 || ddr_if.ddr_we !== 1'b0) begin errors++; $display("FAIL wr_done got busy=%b we=%b exp 0 0", req_if.req_busy, ddr_if.ddr_we); end
    step(); step(); step();
    checks++; if (n_we - we0 != 3) begin errors++; $display("FAIL wr_cycles got %0d exp 3", n_we - we0); end
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL wr_no_valid got %0d exp 0", n_valid - v0); end
  endtask

  task automatic test_rd_wr_both();
    req_if.req_addr = 29'h55; req_if.req_din = 64'h1122_3344_5566_7788; req_if.req_be = 8'hFF;
    req_if.req_rd = 1'b1; req_if.req_we = 1'b1; ddr_if.ddr_busy = 1'b0;
    step();
    req_if.req_we = 1'b0;
    checks++; if (ddr_if.ddr_we !== 1'b1 || ddr_if.ddr_rd !== 1'b0) begin errors++; $display("FAIL both_write_first got we=%b rd=%b exp 1 0", ddr_if.ddr_we, ddr_if.ddr_rd); end
    step();
    step();
    checks++; if (ddr_if.ddr_rd !== 1'b1 || ddr_if.ddr_we !== 1'b0) begin errors++; $display("FAIL both_read_after got rd=%b we=%b exp 1 0", ddr_if.ddr_rd, ddr_if.ddr_we); end
    step();
    ddr_if.ddr_dout = 64'hDEAD_BEEF_0000_0055; ddr_if.ddr_dout_ready = 1'b1;
    step();
    ddr_if.ddr_dout_ready = 1'b0;
    checks++; if (req_if.rsp_valid !== 1'b1 || req_if.rsp_dout !== 64'hDEAD_BEEF_0000_0055) begin errors++; $display("FAIL both_rd_data got v=%b d=%h", req_if.rsp_valid, req_if.rsp_dout); end
    req_if.req_rd = 1'b0;
    step(); step();
  endtask

  task automatic test_timeout();
    int k, v0;
    req_if.req_addr = 29'h77; req_if.req_rd = 1'b1; ddr_if.ddr_busy = 1'b0;
    step();
    step();
    // Now just past the edge that entered RD_WAIT
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (req_if.rsp_valid === 1'b1) begin k = i; break; end
    end
    checks++; if (k != 15) begin errors++; $display("FAIL tmo_latency got %0d exp 15", k); end
    checks++; if (req_if.rsp_dout !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL tmo_data got %h exp ffffffffffffffff", req_if.rsp_dout); end
    req_if.req_rd = 1'b0;
    step(); step();
    v0 = n_valid;
    ddr_if.ddr_dout = 64'h1234; ddr_if.ddr_dout_ready = 1'b1;
    step();
    ddr_if.ddr_dout_ready = 1'b0;
    step(); step();
    checks++; if (n_valid - v0 != 0 || req_if.req_busy !== 1'b0) begin errors++; $display("FAIL tmo_stray_ready got valids=%0d busy=%b exp 0 0", n_valid - v0, req_if.req_busy); end
  endtask

  task automatic test_reset_mid();
    int v0;
    req_if.req_addr = 29'h99; req_if.req_rd = 1'b1; ddr_if.ddr_busy = 1'b1;
    step(); step();
    reset = 1'b1; req_if.req_rd = 1'b0;
    step();
    checks++; if (ddr_if.ddr_rd !== 1'b0 || req_if.req_busy !== 1'b0 || ddr_if.ddr_addr !== 29'h0) begin errors++; $display("FAIL rstmid got rd=%b busy=%b addr=%h exp 0 0 0", ddr_if.ddr_rd, req_if.req_busy, ddr_if.ddr_addr); end
    reset = 1'b0; ddr_if.ddr_busy = 1'b0;
    v0 = n_valid;
    ddr_if.ddr_dout_ready = 1'b1;
    step();
    ddr_if.ddr_dout_ready = 1'b0;
    step(); step();
    checks++; if (n_valid - v0 != 0) begin errors++; $display("FAIL rstmid_stray got %0d exp 0", n_valid - v0); end
  endtask

`ifdef PGM_DDR_RDCACHE_EN
  task automatic test_cache();
    int rd0;
    ddr_if.ddr_busy = 1'b0;
    req_if.req_addr = 29'h40; req_if.req_rd = 1'b1;
    step(); step();
    ddr_if.ddr_dout = 64'h1111_2222_3333_4444; ddr_if.ddr_dout_ready = 1'b1;
    step();
    ddr_if.ddr_dout_ready = 1'b0; req_if.req_rd = 1'b0;
    step(); step();
    req_if.req_din = 64'hCAFE_F00D_0BAD_BEEF; req_if.req_be = 8'hFF; req_if.req_we = 1'b1;
    step();
    req_if.req_we = 1'b0;
    step(); step();
    rd0 = n_rd;
    req_if.req_rd = 1'b1;
    step();
    checks++; if (req_if.rsp_valid !== 1'b1 || req_if.rsp_dout !== 64'hCAFE_F00D_0BAD_BEEF) begin errors++; $display("FAIL cache_hit got v=%b d=%h exp 1 cafef00d0badbeef", req_if.rsp_valid, req_if.rsp_dout); end
    req_if.req_rd = 1'b0;
    step(); step();
    checks++; if (n_rd - rd0 != 0) begin errors++; $display("FAIL cache_no_ddr got %0d exp 0", n_rd - rd0); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_if.req_rd = 1'b1;
    step();
    checks++; if (ddr_if.ddr_rd !== 1'b1) begin errors++; $display("FAIL cache_miss_after_reset got %b exp 1", ddr_if.ddr_rd); end
    step();
    ddr_if.ddr_dout_ready = 1'b1;
    step();
    ddr_if.ddr_dout_ready = 1'b0; req_if.req_rd = 1'b0;
    step(); step();
  endtask
`endif

  initial begin
    reset = 1'b1;
    req_if.req_rd = 1'b0; req_if.req_we = 1'b0; req_if.req_addr = '0;
    req_if.req_din = '0; req_if.req_be = '0;
    ddr_if.ddr_busy = 1'b0; ddr_if.ddr_dout = '0; ddr_if.ddr_dout_ready = 1'b0;
    test_reset();
    test_read_basic();
    test_read_busy();
    test_write();
    test_rd_wr_both();
    test_timeout();
    test_reset_mid();
`ifdef PGM_DDR_RDCACHE_EN
    test_cache();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
